// File: rtl/snake_pkg.sv
// Shared encodings and reset constants for the snake body store.
// Direction codes, FSM state codes and the empty-slot marker live here.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_FREE = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_CHECK     = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    localparam logic [6:0] HEAD_X_RST  = 7'd40;
    localparam logic [6:0] HEAD_Y_RST  = 7'd30;
    localparam logic [6:0] BODY0_X_RST = 7'd39;
    localparam logic [6:0] BODY1_X_RST = 7'd38;
    localparam logic [6:0] BODY_Y_RST  = 7'd30;
    localparam logic [6:0] EMPTY_COORD = 7'h7F;
    localparam int         LENGTH_RST  = 3;

    // Opposite directions differ only in the upper encoding bit.
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a ^ b) == 2'b10;
    endfunction

endpackage

// File: rtl/snake_segment_ram.sv
// Body segment array: one-cycle shift toward the tail, a registered
// read port for the graphic path and a combinational port for the collision scan.
module snake_segment_ram
    import snake_pkg::*;
#(
    parameter int SNAKE_LENGTH_BIT = 6,
    parameter int DEPTH            = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        shift_i,
    input  logic [SNAKE_LENGTH_BIT-1:0] wr_cnt_i,
    input  logic [6:0]                  head_x_i,
    input  logic [6:0]                  head_y_i,
    input  logic [SNAKE_LENGTH_BIT-1:0] rd_idx_i,
    input  logic [SNAKE_LENGTH_BIT-1:0] rd_len_i,
    output logic [6:0]                  rd_x_o,
    output logic [6:0]                  rd_y_o,
    input  logic [SNAKE_LENGTH_BIT-1:0] chk_idx_i,
    output logic [6:0]                  chk_x_o,
    output logic [6:0]                  chk_y_o
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [6:0] bx_q [DEPTH];
    logic [6:0] by_q [DEPTH];
    logic [6:0] rd_x_q, rd_y_q;
    logic [IDX_W-1:0] rd_sel, chk_sel;

    assign rd_sel  = rd_idx_i[IDX_W-1:0];
    assign chk_sel = chk_idx_i[IDX_W-1:0];

    // wr_cnt_i entries are occupied after the shift; one extra slot on grow
    // picks up the old tail value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bx_q[i] <= EMPTY_COORD;
                by_q[i] <= EMPTY_COORD;
            end
            bx_q[0] <= BODY0_X_RST;
            by_q[0] <= BODY_Y_RST;
            bx_q[1] <= BODY1_X_RST;
            by_q[1] <= BODY_Y_RST;
        end else if (shift_i) begin
            bx_q[0] <= head_x_i;
            by_q[0] <= head_y_i;
            for (int i = 1; i < DEPTH; i++) begin
                if (i < int'(wr_cnt_i)) begin
                    bx_q[i] <= bx_q[i-1];
                    by_q[i] <= by_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_x_q <= EMPTY_COORD;
            rd_y_q <= EMPTY_COORD;
        end else if ((int'(rd_idx_i) + 1 >= int'(rd_len_i)) || (int'(rd_idx_i) >= DEPTH)) begin
            rd_x_q <= EMPTY_COORD;
            rd_y_q <= EMPTY_COORD;
        end else begin
            rd_x_q <= bx_q[rd_sel];
            rd_y_q <= by_q[rd_sel];
        end
    end

    assign rd_x_o  = rd_x_q;
    assign rd_y_o  = rd_y_q;
    assign chk_x_o = bx_q[chk_sel];
    assign chk_y_o = by_q[chk_sel];

endmodule

// File: rtl/snake_body_store.sv
// Snake head/body store: steps the snake on move_tick when the graphic path
// is idle, applies wall and self-collision rules, and serves segment reads.
module snake_body_store
    import snake_pkg::*;
#(
    parameter int PIXEL_DISPLAY_BIT = 9,
    parameter int SNAKE_LENGTH_BIT  = 6,
    parameter int MAX_LENGTH        = 16,
    parameter int GRID_W            = 80,
    parameter int GRID_H            = 60
) (
    input  logic                        clock_25,
    input  logic                        reset,
    input  logic                        move_tick,
    input  logic [1:0]                  direction,
    input  logic                        grow,
    input  logic                        semaforo,
    input  logic [SNAKE_LENGTH_BIT-1:0] body_count,
    output logic [6:0]                  snake_head_x,
    output logic [6:0]                  snake_head_y,
    output logic [6:0]                  snake_body_x,
    output logic [6:0]                  snake_body_y,
    output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
    output logic                        update_done,
    output logic                        self_collision,
    output logic                        wall_collision,
    output logic                        busy
);

    localparam logic [SNAKE_LENGTH_BIT-1:0] LEN_ONE = SNAKE_LENGTH_BIT'(1);
    localparam logic [SNAKE_LENGTH_BIT-1:0] LEN_TWO = SNAKE_LENGTH_BIT'(2);
    localparam logic [SNAKE_LENGTH_BIT-1:0] LEN_MAX = SNAKE_LENGTH_BIT'(MAX_LENGTH);

    if ((GRID_H * 8 > (1 << PIXEL_DISPLAY_BIT)) || (MAX_LENGTH >= (1 << SNAKE_LENGTH_BIT))) begin : g_param_chk
        $error("snake_body_store: parameter widths too small for grid/length");
    end

    state_e                      state_q, state_d;
    dir_e                        dir_q, dir_d;
    logic [6:0]                  head_x_q, head_x_d, head_y_q, head_y_d;
    logic [SNAKE_LENGTH_BIT-1:0] len_q, len_d, chk_q, chk_d, wr_cnt;
    logic                        grow_q, grow_d, wall_q, wall_d, self_q, self_d;
    logic [6:0]                  nxt_x, nxt_y, chk_x, chk_y;
    logic                        wall_hit, shift_fire, grow_ok, seg_shift;

    // Wall decision is taken on the current head, before any 7-bit wrap.
    always_comb begin
        nxt_x    = head_x_q;
        nxt_y    = head_y_q;
        wall_hit = 1'b0;
        case (dir_q)
            DIR_UP:    if (head_y_q == 7'd0) wall_hit = 1'b1;
                       else nxt_y = head_y_q - 7'd1;
            DIR_RIGHT: if (head_x_q >= 7'(GRID_W - 1)) wall_hit = 1'b1;
                       else nxt_x = head_x_q + 7'd1;
            DIR_DOWN:  if (head_y_q >= 7'(GRID_H - 1)) wall_hit = 1'b1;
                       else nxt_y = head_y_q + 7'd1;
            default:   if (head_x_q == 7'd0) wall_hit = 1'b1;
                       else nxt_x = head_x_q - 7'd1;
        endcase
    end

    assign shift_fire = (state_q == ST_SHIFT) && !semaforo;
    assign grow_ok    = grow_q && (len_q < LEN_MAX);
    assign seg_shift  = shift_fire && !wall_hit;
    assign wr_cnt     = grow_ok ? len_q : len_q - LEN_ONE;

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        len_d    = len_q;
        chk_d    = chk_q;
        wall_d   = wall_q;
        self_d   = self_q;
        grow_d   = grow | (grow_q & ~shift_fire);
        case (state_q)
            ST_IDLE: begin
                if (move_tick && !wall_q && !self_q) begin
                    state_d = ST_WAIT_FREE;
                    if (!is_reverse(direction, dir_q)) dir_d = dir_e'(direction);
                end
            end
            ST_WAIT_FREE: if (!semaforo) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (shift_fire) begin
                    if (wall_hit) begin
                        wall_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        head_x_d = nxt_x;
                        head_y_d = nxt_y;
                        if (grow_ok) len_d = len_q + LEN_ONE;
                        chk_d   = '0;
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (chk_x == head_x_q && chk_y == head_y_q) self_d = 1'b1;
                if (chk_q == len_q - LEN_TWO) state_d = ST_DONE;
                else chk_d = chk_q + LEN_ONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            dir_q    <= DIR_RIGHT;
            head_x_q <= HEAD_X_RST;
            head_y_q <= HEAD_Y_RST;
            len_q    <= SNAKE_LENGTH_BIT'(LENGTH_RST);
            chk_q    <= '0;
            grow_q   <= 1'b0;
            wall_q   <= 1'b0;
            self_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            len_q    <= len_d;
            chk_q    <= chk_d;
            grow_q   <= grow_d;
            wall_q   <= wall_d;
            self_q   <= self_d;
        end
    end

    snake_segment_ram #(
        .SNAKE_LENGTH_BIT(SNAKE_LENGTH_BIT),
        .DEPTH           (MAX_LENGTH - 1)
    ) u_segments (
        .clk      (clock_25),
        .rst_n    (reset),
        .shift_i  (seg_shift),
        .wr_cnt_i (wr_cnt),
        .head_x_i (head_x_q),
        .head_y_i (head_y_q),
        .rd_idx_i (body_count),
        .rd_len_i (len_q),
        .rd_x_o   (snake_body_x),
        .rd_y_o   (snake_body_y),
        .chk_idx_i(chk_q),
        .chk_x_o  (chk_x),
        .chk_y_o  (chk_y)
    );

    assign snake_head_x   = head_x_q;
    assign snake_head_y   = head_y_q;
    assign snake_length   = len_q;
    assign update_done    = (state_q == ST_DONE);
    assign busy           = (state_q != ST_IDLE);
    assign self_collision = self_q;
    assign wall_collision = wall_q;

endmodule

// File: tb/tb_snake_body_store.sv
// Directed bench for snake_body_store with a behavioural snake model and a
// scoreboard of expected step results.
module tb_snake_body_store;

    logic       clock_25 = 1'b0;
    logic       reset = 1'b0;
    logic       move_tick = 1'b0;
    logic [1:0] direction = 2'b01;
    logic       grow = 1'b0;
    logic       semaforo = 1'b0;
    logic [5:0] body_count = 6'd0;
    logic [6:0] snake_head_x, snake_head_y, snake_body_x, snake_body_y;
    logic [5:0] snake_length;
    logic       update_done, self_collision, wall_collision, busy;

    snake_body_store dut (
        .clock_25      (clock_25),
        .reset         (reset),
        .move_tick     (move_tick),
        .direction     (direction),
        .grow          (grow),
        .semaforo      (semaforo),
        .body_count    (body_count),
        .snake_head_x  (snake_head_x),
        .snake_head_y  (snake_head_y),
        .snake_body_x  (snake_body_x),
        .snake_body_y  (snake_body_y),
        .snake_length  (snake_length),
        .update_done   (update_done),
        .self_collision(self_collision),
        .wall_collision(wall_collision),
        .busy          (busy)
    );

    always #20 clock_25 = ~clock_25;

    typedef struct {
        int hx;
        int hy;
        int len;
        bit wall;
        bit selfc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    int   m_hx, m_hy, m_len, m_dir;
    int   m_bx[15];
    int   m_by[15];
    bit   m_grow, m_wall, m_self;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_hx = 40; m_hy = 30; m_len = 3; m_dir = 1;
        m_grow = 0; m_wall = 0; m_self = 0;
        for (int i = 0; i < 15; i++) begin
            m_bx[i] = 127;
            m_by[i] = 127;
        end
        m_bx[0] = 39; m_by[0] = 30;
        m_bx[1] = 38; m_by[1] = 30;
        sb.delete();
    endtask

    task automatic model_step(input int d, output bit acc, output bit wall_now);
        exp_t e;
        int   nx, ny;
        bit   g;
        acc = 0;
        wall_now = 0;
        if (m_wall || m_self) return;
        acc = 1;
        if (!((d == 0 && m_dir == 2) || (d == 2 && m_dir == 0) ||
              (d == 1 && m_dir == 3) || (d == 3 && m_dir == 1)))
            m_dir = d;
        nx = m_hx;
        ny = m_hy;
        case (m_dir)
            0: ny = ny - 1;
            1: nx = nx + 1;
            2: ny = ny + 1;
            default: nx = nx - 1;
        endcase
        g = m_grow;
        m_grow = 0;
        if (nx < 0 || nx >= 80 || ny < 0 || ny >= 60) begin
            m_wall = 1;
            wall_now = 1;
        end else begin
            if (g && m_len < 16) m_len++;
            for (int i = m_len - 2; i > 0; i--) begin
                m_bx[i] = m_bx[i-1];
                m_by[i] = m_by[i-1];
            end
            m_bx[0] = m_hx; m_by[0] = m_hy;
            m_hx = nx; m_hy = ny;
            for (int i = 0; i < m_len - 1; i++)
                if (m_bx[i] == m_hx && m_by[i] == m_hy) m_self = 1;
        end
        e.hx = m_hx; e.hy = m_hy; e.len = m_len; e.wall = m_wall; e.selfc = m_self;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clock_25);
        reset = 1'b0;
        move_tick = 1'b0;
        grow = 1'b0;
        semaforo = 1'b0;
        repeat (2) @(negedge clock_25);
        reset = 1'b1;
        model_reset();
        @(negedge clock_25);
    endtask

    task automatic grow_pulse();
        @(negedge clock_25);
        grow = 1'b1;
        m_grow = 1;
        @(negedge clock_25);
        grow = 1'b0;
    endtask

    task automatic read_body(input int idx, output int ox, output int oy);
        @(negedge clock_25);
        body_count = 6'(idx);
        @(negedge clock_25);
        ox = int'(snake_body_x);
        oy = int'(snake_body_y);
    endtask

    task automatic verify_body();
        int ox, oy;
        for (int i = 0; i < m_len; i++) begin
            read_body(i, ox, oy);
            if (i < m_len - 1) begin
                check($sformatf("body_x[%0d]", i), ox, m_bx[i]);
                check($sformatf("body_y[%0d]", i), oy, m_by[i]);
            end else begin
                check($sformatf("empty_x[%0d]", i), ox, 127);
                check($sformatf("empty_y[%0d]", i), oy, 127);
            end
        end
    endtask

    task automatic do_move(input int d, input int hold);
        bit   acc, wall_now, g0;
        int   n, hx0, hy0;
        exp_t e;
        hx0 = m_hx; hy0 = m_hy; g0 = m_grow;
        @(negedge clock_25);
        move_tick = 1'b1;
        direction = 2'(d);
        if (hold > 0) semaforo = 1'b1;
        model_step(d, acc, wall_now);
        @(negedge clock_25);
        move_tick = 1'b0;
        if (!acc) begin
            repeat (4) @(negedge clock_25);
            check("ignored_busy", busy, 0);
            check("ignored_hx", snake_head_x, hx0);
            check("ignored_hy", snake_head_y, hy0);
            return;
        end
        for (int c = 1; c < hold; c++) begin
            if (c == 50) begin
                move_tick = 1'b1;
                direction = 2'd2;
            end else begin
                move_tick = 1'b0;
            end
            if (c % 20 == 0) begin
                check("sem_busy", busy, 1);
                check("sem_hx", snake_head_x, hx0);
                check("sem_hy", snake_head_y, hy0);
            end
            @(negedge clock_25);
        end
        move_tick = 1'b0;
        semaforo = 1'b0;
        n = (hold > 0) ? 0 : 1;
        while (!update_done && n < 200) begin
            @(negedge clock_25);
            n++;
        end
        check("done_seen", (n < 200), 1);
        if (n < 200) begin
            if (wall_now) check("wall_latency", n, 3);
            else if (hold > 0) check("sem_latency", (n >= m_len && n <= m_len + 1), 1);
            else if (!g0) check("step_latency", n, m_len + 2);
            e = sb.pop_front();
            check("head_x", snake_head_x, e.hx);
            check("head_y", snake_head_y, e.hy);
            check("length", snake_length, e.len);
            check("wall_flag", wall_collision, e.wall);
            check("self_flag", self_collision, e.selfc);
            @(negedge clock_25);
            check("done_pulse", update_done, 0);
        end
    endtask

    initial begin
        int ox, oy;
        model_reset();
        repeat (3) @(negedge clock_25);
        check("rst_hold_busy", busy, 0);
        check("rst_hold_hx", snake_head_x, 40);
        reset = 1'b1;
        @(negedge clock_25);
        check("rst_hx", snake_head_x, 40);
        check("rst_hy", snake_head_y, 30);
        check("rst_len", snake_length, 3);
        check("rst_done", update_done, 0);
        check("rst_self", self_collision, 0);
        check("rst_wall", wall_collision, 0);
        verify_body();
        read_body(4, ox, oy);
        check("rst_empty4_x", ox, 127);

        // First step right, then a step held off by the graphic path, then grow.
        do_move(1, 0);
        verify_body();
        do_move(1, 100);
        grow_pulse();
        do_move(1, 0);
        verify_body();

        // Self collision at length 5; left right after right is ignored.
        apply_reset();
        grow_pulse(); do_move(1, 0);
        grow_pulse(); do_move(3, 0);
        check("reverse_hx", snake_head_x, 42);
        do_move(1, 0); do_move(2, 0); do_move(3, 0); do_move(0, 0);
        check("self_set", self_collision, 1);
        do_move(1, 0);

        // Wall on the right edge; later ticks ignored.
        apply_reset();
        while (m_hx < 79 && !m_wall) do_move(1, 0);
        do_move(1, 0);
        check("wall_set", wall_collision, 1);
        check("wall_hx", snake_head_x, 79);
        do_move(2, 0);

        // Grow to the maximum length and beyond.
        apply_reset();
        repeat (13) begin
            grow_pulse();
            do_move(1, 0);
        end
        check("len_max", snake_length, 16);
        grow_pulse();
        do_move(1, 0);
        check("len_capped", snake_length, 16);
        verify_body();

        // Reset during the collision scan.
        apply_reset();
        @(negedge clock_25);
        move_tick = 1'b1;
        direction = 2'd1;
        @(negedge clock_25);
        move_tick = 1'b0;
        repeat (2) @(negedge clock_25);
        check("mid_busy", busy, 1);
        check("mid_hx", snake_head_x, 41);
        #5 reset = 1'b0;
        #1;
        check("abort_hx", snake_head_x, 40);
        check("abort_hy", snake_head_y, 30);
        check("abort_len", snake_length, 3);
        check("abort_busy", busy, 0);
        check("abort_done", update_done, 0);
        @(negedge clock_25);
        reset = 1'b1;
        model_reset();
        verify_body();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
